uart_rx_frame_check: RTL and testbench
======================================

// Module: uart_rx_frame_check
// PURPOSE
//  Parametrised UART Rx frame checker between bit deserialiser and Rx consumer.
//  Checks parity (even/odd/off, run-time select) and stop bit(s), then holds the checked frame in a 1-entry valid/ready register.
//  Keeps sticky parity/framing/overrun status; error counters are optional.
// PARAMETERS
//  DATA_WIDTH  8  data bits per frame, 5..9
//  STOP_BITS   1  stop bits checked, 1 or 2
//  CNT_WIDTH   8  width of each saturating error counter
// PORTS
//  clock          in   1           block clock, all flops rising edge
//  reset          in   1           asynchronous, active-low reset
//  frame_valid    in   1           1-cycle strobe: fields below are a complete frame
//  frame_data     in   DATA_WIDTH  received data bits, LSB = first bit on line
//  frame_parity   in   1           received parity bit
//  frame_stop     in   2           received stop bits; [1] ignored when STOP_BITS=1
//  parity_en      in   1           1 = parity checked, 0 = no parity in frame
//  parity_type    in   1           0 = EVEN_PARITY, 1 = ODD_PARITY
//  out_ready      in   1           consumer accepts out_* this cycle
//  out_valid      out  1           holding register full
//  out_data       out  DATA_WIDTH  held data
//  out_parity_err out  1           held frame failed parity
//  out_frame_err  out  1           held frame had a 0 stop bit
//  status_clr     in   1           clears sticky flags and counters
//  sts_parity     out  1           sticky: any parity error since clear
//  sts_frame      out  1           sticky: any framing error since clear
//  sts_overrun    out  1           sticky: frame dropped, holding register full
//  parity_err_cnt out  CNT_WIDTH   saturating parity-error count
//  frame_err_cnt  out  CNT_WIDTH   saturating framing-error count
// BEHAVIOUR
//  - One clock, reset async active-low. While reset=0 all outputs = 0.
//  - Parity error, combinational on frame_* inputs:
//    parity_en=0 -> 0; EVEN: (^frame_data)^frame_parity; ODD: ~((^frame_data)^frame_parity).
//  - Framing error: ~frame_stop[0], OR'd with ~frame_stop[1] when STOP_BITS=2.
//  - Holding register: two states, EMPTY/FULL; out_valid=1 in FULL.
//    EMPTY & frame_valid -> FULL next cycle; data/errors registered (latency 1).
//    FULL & out_ready & ~frame_valid -> EMPTY.
//    FULL & out_ready & frame_valid -> stays FULL, new frame loaded (back-to-back).
//    FULL & ~out_ready & frame_valid -> overrun: new frame dropped, held frame unchanged,
//      sts_overrun set. Dropped frame's parity/framing errors are still recorded
//      (sticky flags and counters).
//  - out_* stable while out_valid & ~out_ready.
//  - Sticky flags set on the frame_valid cycle, visible next cycle. status_clr clears them.
//    Set and status_clr in the same cycle -> set wins (flag = 1).
//  - Counters: +1 per erroneous frame, saturate at all-ones, no wrap.
//    status_clr alone -> 0; status_clr with event -> 1.
//  - Reset mid-frame: holding register emptied, flags/counters = 0, no partial state kept.
// CONFIGURATION
//  UART_RX_ERR_CNT_EN defined: both counters implemented as above.
//  Not defined: no counter flops; parity_err_cnt/frame_err_cnt tied to 0; ports kept.
// STRUCTURE
//  uart_rx_pkg: EVEN_PARITY=1'b0, ODD_PARITY=1'b1 localparams; EMPTY/FULL state encoding.
//  Sub-module uart_err_counter (CNT_WIDTH, inc, clr, count; saturating, clr+inc -> 1),
//  instantiated twice under UART_RX_ERR_CNT_EN.
// TESTING
//  1 EVEN, data 8'hA5, parity 0, stop 1, out_ready=1 -> out_valid next cycle, data A5, no errors.
//  2 ODD, data 8'hA5, parity 0 -> out_parity_err=1, sts_parity=1, parity_err_cnt=1;
//    parity_en=0, same frame -> no error.
//  3 STOP_BITS=2, frame_stop=2'b01 -> out_frame_err=1, sts_frame=1; 2'b11 -> clean.
//  4 out_ready=0, frames 8'h11 then 8'h22 -> out_data stays 11, sts_overrun=1; raise
//    out_ready -> 11 consumed, out_valid=0.
//  5 CNT_WIDTH=2, 5 parity-error frames -> cnt 1,2,3,3,3; status_clr with 6th error -> cnt 1, sts_parity=1.
//  6 reset=0 asynchronously while FULL with sticky flags set -> all outputs 0 immediately;
//    macro undefined -> counters read 0 throughout.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART Rx frame checker.
//   EVEN_PARITY / ODD_PARITY : encodings of the parity_type input
//   hold_state_t             : holding-register state (EMPTY / FULL)
package uart_rx_pkg;

  localparam logic EVEN_PARITY = 1'b0;
  localparam logic ODD_PARITY  = 1'b1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } hold_state_t;

endpackage : uart_rx_pkg

// File: rtl/uart_err_counter.sv
// Saturating event counter for the UART Rx error statistics.
// Ports:
//   clock  in   block clock
//   reset  in   asynchronous active-low reset
//   inc    in   count one event this cycle
//   clr    in   clear; an event in the same cycle leaves the count at 1
//   count  out  current count, sticks at all-ones
module uart_err_counter #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 inc,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] count
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? CNT_WIDTH'(1) : '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_WIDTH'(1);
    end
  end

endmodule : uart_err_counter

// File: rtl/uart_rx_frame_check.sv
// UART Rx frame checker: checks parity and stop bits of each deserialised
// frame and holds the result in a one-entry valid/ready register. Keeps
// sticky parity/framing/overrun flags.
// Build option: define UART_RX_ERR_CNT_EN to implement the saturating
// parity/framing error counters; otherwise the count ports read 0.
// Ports:
//   clock, reset                  clock, async active-low reset
//   frame_valid/data/parity/stop  incoming frame (1-cycle strobe)
//   parity_en, parity_type        parity on/off, 0 = even, 1 = odd
//   out_valid/ready/data/..._err  checked frame, valid/ready handshake
//   status_clr                    clears sticky flags and counters
//   sts_parity/frame/overrun      sticky error flags
//   parity_err_cnt/frame_err_cnt  saturating error counters
//
// state | meaning
// ------+-------------------------------------------------
// EMPTY | no frame held, out_valid = 0
// FULL  | checked frame held on out_*, waiting for out_ready
module uart_rx_frame_check
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  frame_valid,
  input  logic [DATA_WIDTH-1:0] frame_data,
  input  logic                  frame_parity,
  input  logic [1:0]            frame_stop,
  input  logic                  parity_en,
  input  logic                  parity_type,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_parity_err,
  output logic                  out_frame_err,
  input  logic                  status_clr,
  output logic                  sts_parity,
  output logic                  sts_frame,
  output logic                  sts_overrun,
  output logic [CNT_WIDTH-1:0]  parity_err_cnt,
  output logic [CNT_WIDTH-1:0]  frame_err_cnt
);

  hold_state_t state_q, state_d;
  logic        parity_err_c;
  logic        frame_err_c;
  logic        load;
  logic        overrun;
  logic        parity_evt;
  logic        frame_evt;

  // Odd parity is the even check inverted.
  assign parity_err_c = parity_en &
                        ((^frame_data) ^ frame_parity ^ (parity_type == ODD_PARITY));

  // Second stop bit only counts when two are configured.
  assign frame_err_c = ~frame_stop[0] | ((STOP_BITS == 2) & ~frame_stop[1]);

  // Errors are recorded for every frame seen, including dropped ones.
  assign parity_evt = frame_valid & parity_err_c;
  assign frame_evt  = frame_valid & frame_err_c;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    overrun = 1'b0;
    case (state_q)
      EMPTY: begin
        if (frame_valid) begin
          load    = 1'b1;
          state_d = FULL;
        end
      end
      FULL: begin
        if (frame_valid) begin
          // Back-to-back reload when the held frame leaves this cycle.
          if (out_ready) begin
            load = 1'b1;
          end else begin
            overrun = 1'b1;
          end
        end else if (out_ready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  assign out_valid = (state_q == FULL);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_data       <= '0;
      out_parity_err <= 1'b0;
      out_frame_err  <= 1'b0;
    end else if (load) begin
      out_data       <= frame_data;
      out_parity_err <= parity_err_c;
      out_frame_err  <= frame_err_c;
    end
  end

  // Set has priority over clear so an error arriving with status_clr is kept.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sts_parity  <= 1'b0;
      sts_frame   <= 1'b0;
      sts_overrun <= 1'b0;
    end else begin
      sts_parity  <= (sts_parity  & ~status_clr) | parity_evt;
      sts_frame   <= (sts_frame   & ~status_clr) | frame_evt;
      sts_overrun <= (sts_overrun & ~status_clr) | overrun;
    end
  end

`ifdef UART_RX_ERR_CNT_EN
  uart_err_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_parity_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (parity_evt),
    .clr   (status_clr),
    .count (parity_err_cnt)
  );

  uart_err_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_frame_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (frame_evt),
    .clr   (status_clr),
    .count (frame_err_cnt)
  );
`else
  assign parity_err_cnt = '0;
  assign frame_err_cnt  = '0;
`endif

endmodule : uart_rx_frame_check

// File: tb/tb_uart_rx_frame_check.sv
// Directed bench for uart_rx_frame_check (STOP_BITS=2, CNT_WIDTH=2).
// Accepted frames are pushed into an expected queue; a monitor pops and
// compares on every out_valid & out_ready cycle. Sticky flags and counters
// are checked against a small reference model after each stimulus step.
module tb_uart_rx_frame_check;

  localparam int DW = 8;
  localparam int CW = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          frame_valid;
  logic [DW-1:0] frame_data;
  logic          frame_parity;
  logic [1:0]    frame_stop;
  logic          parity_en;
  logic          parity_type;
  logic          out_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_parity_err;
  logic          out_frame_err;
  logic          status_clr;
  logic          sts_parity;
  logic          sts_frame;
  logic          sts_overrun;
  logic [CW-1:0] parity_err_cnt;
  logic [CW-1:0] frame_err_cnt;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          pe;
    logic          fe;
  } exp_t;

  exp_t q[$];

  int vectors     = 0;
  int miscompares = 0;

  logic          m_sp, m_sf, m_so;
  logic [CW-1:0] m_pc, m_fc;

  always #5 clock = ~clock;

  uart_rx_frame_check #(
    .DATA_WIDTH (DW),
    .STOP_BITS  (2),
    .CNT_WIDTH  (CW)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .frame_valid    (frame_valid),
    .frame_data     (frame_data),
    .frame_parity   (frame_parity),
    .frame_stop     (frame_stop),
    .parity_en      (parity_en),
    .parity_type    (parity_type),
    .out_ready      (out_ready),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_parity_err (out_parity_err),
    .out_frame_err  (out_frame_err),
    .status_clr     (status_clr),
    .sts_parity     (sts_parity),
    .sts_frame      (sts_frame),
    .sts_overrun    (sts_overrun),
    .parity_err_cnt (parity_err_cnt),
    .frame_err_cnt  (frame_err_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every handshake must match the oldest expected frame.
  always @(negedge clock) begin
    if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_out: got data %0h with empty expected queue", out_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_data", 32'(out_data), 32'(e.d));
        chk("out_parity_err", 32'(out_parity_err), 32'(e.pe));
        chk("out_frame_err", 32'(out_frame_err), 32'(e.fe));
      end
    end
  end

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == '1) ? c : c + CW'(1);
  endfunction

  task automatic model_clear();
    m_sp = 0; m_sf = 0; m_so = 0; m_pc = '0; m_fc = '0;
  endtask

  task automatic check_status(input string tag);
    chk({tag, ".sts_parity"}, 32'(sts_parity), 32'(m_sp));
    chk({tag, ".sts_frame"}, 32'(sts_frame), 32'(m_sf));
    chk({tag, ".sts_overrun"}, 32'(sts_overrun), 32'(m_so));
`ifdef UART_RX_ERR_CNT_EN
    chk({tag, ".parity_err_cnt"}, 32'(parity_err_cnt), 32'(m_pc));
    chk({tag, ".frame_err_cnt"}, 32'(frame_err_cnt), 32'(m_fc));
`else
    chk({tag, ".parity_err_cnt"}, 32'(parity_err_cnt), 32'd0);
    chk({tag, ".frame_err_cnt"}, 32'(frame_err_cnt), 32'd0);
`endif
  endtask

  // pe/fe are hand-computed expected errors; accept=0 means the frame is
  // expected to be dropped as an overrun.
  task automatic send(input logic [DW-1:0] d, input logic par, input logic [1:0] stp,
                      input logic pen, input logic ptype, input logic pe, input logic fe,
                      input logic accept, input logic clr);
    frame_valid  = 1'b1;
    frame_data   = d;
    frame_parity = par;
    frame_stop   = stp;
    parity_en    = pen;
    parity_type  = ptype;
    status_clr   = clr;
    if (accept) q.push_back('{d: d, pe: pe, fe: fe});
    if (clr) begin
      m_sp = pe; m_sf = fe; m_so = !accept;
      m_pc = CW'(pe); m_fc = CW'(fe);
    end else begin
      m_sp = m_sp | pe; m_sf = m_sf | fe; m_so = m_so | !accept;
      if (pe) m_pc = sat_inc(m_pc);
      if (fe) m_fc = sat_inc(m_fc);
    end
    @(posedge clock); #1;
    frame_valid = 1'b0;
    status_clr  = 1'b0;
  endtask

  task automatic clear();
    status_clr = 1'b1;
    @(posedge clock); #1;
    status_clr = 1'b0;
    model_clear();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
    end
  endtask

  initial begin
    reset = 1'b0;
    frame_valid = 0; frame_data = '0; frame_parity = 0; frame_stop = 2'b11;
    parity_en = 1; parity_type = 0; out_ready = 1; status_clr = 0;
    model_clear();
    #2;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_data", 32'(out_data), 32'd0);
    check_status("rst");
    idle(2);
    reset = 1'b1;
    idle(1);

    // 1: even parity, clean frame
    send(8'hA5, 0, 2'b11, 1, 0, 0, 0, 1, 0);
    chk("t1.out_valid", 32'(out_valid), 32'd1);
    check_status("t1");
    idle(1);

    // 2: odd parity error, then same frame with parity disabled
    send(8'hA5, 0, 2'b11, 1, 1, 1, 0, 1, 0);
    check_status("t2a");
    clear();
    send(8'hA5, 0, 2'b11, 0, 1, 0, 0, 1, 0);
    check_status("t2b");
    idle(1);

    // 3: second stop bit low, first stop bit low, then clean
    clear();
    send(8'hA5, 0, 2'b01, 1, 0, 0, 1, 1, 0);
    check_status("t3a");
    send(8'h3C, 0, 2'b10, 1, 0, 0, 1, 1, 0);
    check_status("t3b");
    clear();
    send(8'hA5, 0, 2'b11, 1, 0, 0, 0, 1, 0);
    check_status("t3c");
    idle(2);

    // 4: overrun; dropped frame carries a parity error that must still count
    clear();
    out_ready = 1'b0;
    send(8'h11, 0, 2'b11, 1, 0, 0, 0, 1, 0);
    send(8'h22, 0, 2'b11, 1, 1, 1, 0, 0, 0);
    chk("t4.out_data_held", 32'(out_data), 32'h11);
    chk("t4.out_perr_held", 32'(out_parity_err), 32'd0);
    check_status("t4");
    idle(2);
    chk("t4.out_data_stable", 32'(out_data), 32'h11);
    chk("t4.out_valid_stable", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    idle(1);
    chk("t4.out_valid_drained", 32'(out_valid), 32'd0);

    // back-to-back frames with the consumer always ready
    send(8'h33, 0, 2'b11, 1, 0, 0, 0, 1, 0);
    send(8'h44, 1, 2'b11, 1, 1, 0, 0, 1, 0);
    chk("t4b.out_data", 32'(out_data), 32'h44);
    idle(2);

    // 5: counter saturation, then clear together with an error
    clear();
    for (int i = 0; i < 5; i++) begin
      send(8'h01, 0, 2'b11, 1, 0, 1, 0, 1, 0);
      check_status($sformatf("t5.%0d", i));
    end
    send(8'h01, 0, 2'b11, 1, 0, 1, 0, 1, 1);
    check_status("t5.clr_err");
    idle(2);
    chk("t5.queue_empty", 32'(q.size()), 32'd0);

    // 6: async reset while FULL with flags set
    out_ready = 1'b0;
    send(8'h7E, 0, 2'b00, 1, 1, 1, 1, 0, 0);
    q.delete();
    #2 reset = 1'b0;
    #1;
    model_clear();
    chk("t6.out_valid", 32'(out_valid), 32'd0);
    chk("t6.out_data", 32'(out_data), 32'd0);
    chk("t6.out_parity_err", 32'(out_parity_err), 32'd0);
    chk("t6.out_frame_err", 32'(out_frame_err), 32'd0);
    check_status("t6");
    idle(1);
    reset = 1'b1;
    out_ready = 1'b1;
    idle(2);
    chk("t6.post_valid", 32'(out_valid), 32'd0);
    check_status("t6.post");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule : tb_uart_rx_frame_check
